// File: rtl/register_en_clr.sv
// D register with synchronous reset, synchronous clear and load enable.
// Latency 1 cycle (D -> Q); no backpressure, Q is driven straight from the flop.
module register_en_clr #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  // rst_l is asserted high despite its name; reset beats flush, flush beats load.
  always_ff @(posedge clk) begin
    if (rst_l) begin
      Q <= RESET_VAL;
    end else if (clear) begin
      Q <= '0;
    end else if (en) begin
      Q <= D;
    end
  end

endmodule

// File: tb/tb_register_en_clr.sv
// Bench for register_en_clr: directed priority/flush/glitch steps, then random
// stimulus on 8-, 1- and 32-bit instances against a next-value reference model.
module tb_register_en_clr;

  logic        clk;
  logic        rst_l;
  logic        en;
  logic        clear;
  logic [7:0]  d8;
  logic        d1;
  logic [31:0] d32;
  logic [7:0]  q8;
  logic        q1;
  logic [31:0] q32;

  logic [7:0]  m8;
  logic        m1;
  logic [31:0] m32;

  int checks = 0;
  int errors = 0;

  register_en_clr #(8, 8'hA5) u_r8 (
    .clk(clk), .rst_l(rst_l), .en(en), .clear(clear), .D(d8), .Q(q8)
  );

  register_en_clr #(.WIDTH(1), .RESET_VAL(1'b0)) u_r1 (
    .clk(clk), .rst_l(rst_l), .en(en), .clear(clear), .D(d1), .Q(q1)
  );

  register_en_clr u_r32 (
    .clk(clk), .rst_l(rst_l), .en(en), .clear(clear), .D(d32), .Q(q32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Value the register must hold after an edge, straight from the priority rules.
  function automatic logic [31:0] next_val(input logic r, input logic c, input logic e,
                                           input logic [31:0] d, input logic [31:0] q,
                                           input logic [31:0] rv);
    if (r) return rv;
    if (c) return 32'd0;
    if (e) return d;
    return q;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_models(input string tag);
    check({tag, "/q8"},  {24'd0, q8},  {24'd0, m8});
    check({tag, "/q1"},  {31'd0, q1},  {31'd0, m1});
    check({tag, "/q32"}, q32, m32);
  endtask

  // Apply inputs, take one edge, advance the model, then sample 1ns later.
  task automatic step(input logic r, input logic c, input logic e,
                      input logic [7:0] v8, input logic v1, input logic [31:0] v32,
                      input string tag);
    rst_l = r; clear = c; en = e; d8 = v8; d1 = v1; d32 = v32;
    @(posedge clk);
    m8  = 8'(next_val(r, c, e, {24'd0, v8}, {24'd0, m8}, 32'h0000_00A5));
    m1  = 1'(next_val(r, c, e, {31'd0, v1}, {31'd0, m1}, 32'd0));
    m32 = next_val(r, c, e, v32, m32, 32'd0);
    #1;
    check_models(tag);
  endtask

  initial begin
    rst_l = 1'b0; en = 1'b0; clear = 1'b0; d8 = '0; d1 = 1'b0; d32 = '0;
    m8 = 'x; m1 = 1'bx; m32 = 'x;
    @(negedge clk);

    // Reset wins over a pending load.
    step(1, 0, 1, 8'h3C, 1'b1, 32'hDEAD_BEEF, "reset");
    check("reset_a5", {24'd0, q8}, 32'h0000_00A5);
    check("reset_q32", q32, 32'd0);

    step(0, 0, 1, 8'h3C, 1'b0, 32'h1234_5678, "load");
    check("load_3c", {24'd0, q8}, 32'h0000_003C);

    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 8'hFF, 1'b1, 32'hFFFF_FFFF, "hold");
      check("hold_3c", {24'd0, q8}, 32'h0000_003C);
    end

    step(0, 1, 1, 8'h77, 1'b1, 32'h7777_7777, "clear_over_en");
    check("clear_zero", {24'd0, q8}, 32'd0);

    step(0, 0, 1, 8'h3C, 1'b1, 32'h0000_0001, "reload");
    step(1, 1, 1, 8'h77, 1'b1, 32'h5555_5555, "reset_over_clear");
    check("reset_over_clear_a5", {24'd0, q8}, 32'h0000_00A5);

    // Reset held across several edges keeps RESET_VAL, then release loads normally.
    step(1, 0, 1, 8'h11, 1'b1, 32'h1111_1111, "reset_hold1");
    step(1, 0, 0, 8'h22, 1'b1, 32'h2222_2222, "reset_hold2");
    step(0, 0, 1, 8'h5A, 1'b0, 32'hA5A5_A5A5, "release_load");
    check("release_5a", {24'd0, q8}, 32'h0000_005A);

    // Pending-flag use of the 1-bit instance.
    step(0, 0, 1, 8'h01, 1'b1, 32'h0, "flag_set");
    check("flag_set_q1", {31'd0, q1}, 32'd1);
    step(0, 1, 1, 8'h02, 1'b1, 32'h0, "flag_flush");
    check("flag_flush_q1", {31'd0, q1}, 32'd0);
    step(0, 0, 1, 8'h03, 1'b0, 32'h0, "flag_idle");
    check("flag_idle_q1", {31'd0, q1}, 32'd0);

    // Between edges, input activity must not reach Q.
    for (int i = 0; i < 6; i++) begin
      en  = ~en;
      d8  = 8'($urandom);
      d1  = ~d1;
      d32 = $urandom;
      #1;
      check_models("glitch");
    end

    // Randomized traffic: rare reset, occasional flush, frequent loads.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom), $urandom,
           "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
